// File: rtl/lfsr_rng.sv
// lfsr_rng: parametrised Fibonacci LFSR with runtime seed load and a request/response
// port returning a uniform value in [0, bound) by mask-and-reject sampling.
// TAP_MASK and SEED are WIDTH bits wide; instances with WIDTH != 64 must override both.
module lfsr_rng #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] TAP_MASK  = 64'h1B,
    parameter logic [WIDTH-1:0] SEED      = 64'h1234_5678_8765_4321,
    parameter int unsigned      STEPS     = 1,
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_RETRY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] lfsr,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_bound,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_fallback
);

    localparam int unsigned CntW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [WIDTH-1:0] One = {{(WIDTH - 1){1'b0}}, 1'b1};
    // An all-zero state would lock the register up, so zero seeds become 1.
    localparam logic [WIDTH-1:0] SeedInit = (SEED == '0) ? One : SEED;
    localparam logic [CntW-1:0] LastTry = CntW'(MAX_RETRY - 1);

    typedef enum logic [1:0] {StIdle, StDraw, StResp} fsm_e;

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [OUT_W-1:0] bound_q;
    logic [OUT_W-1:0] mask_q;
    logic [CntW-1:0]  retry_cnt_q;
    logic [OUT_W-1:0] rsp_data_q;
    logic             rsp_fallback_q;

    logic [WIDTH-1:0] state_adv;
    logic [WIDTH-1:0] seed_val;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;
    logic             last_try;
    logic             accept;
    logic             draw_adv;
    logic             step_adv;

    // One serial shift: parity of tapped bits enters at the top.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        return {^(s & TAP_MASK), s[WIDTH-1:1]};
    endfunction

    // STEPS shifts in one cycle; a zero state escapes to 1 instead of shifting.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        if (s == '0) begin
            r = One;
        end else begin
            r = s;
            for (int unsigned i = 0; i < STEPS; i++) begin
                r = shift_once(r);
            end
        end
        return r;
    endfunction

    // Smallest 2^k-1 covering bound-1; bound 0 wraps to all ones, i.e. the full range.
    function automatic logic [OUT_W-1:0] mask_for(input logic [OUT_W-1:0] bound);
        logic [OUT_W-1:0] m;
        m = bound - OUT_W'(1);
        for (int unsigned i = 1; i < OUT_W; i++) begin
            m = m | (m >> i);
        end
        return m;
    endfunction

    assign lfsr         = state_q;
    assign rsp_valid    = (fsm_q == StResp);
    assign rsp_data     = rsp_data_q;
    assign rsp_fallback = rsp_fallback_q;
    // A seed load in the same cycle would clobber the first draw, so refuse it.
    assign req_ready    = (fsm_q == StIdle) && !rst && !seed_valid;

    // Draw evaluation and advance decisions for the current cycle.
    always_comb begin
        state_adv = advance(state_q);
        seed_val  = (seed_data == '0) ? One : seed_data;
        cand      = state_q[OUT_W-1:0] & mask_q;
        cand_ok   = (bound_q == '0) || (cand < bound_q);
        last_try  = (retry_cnt_q == LastTry);
        accept    = req_valid && req_ready;
        draw_adv  = accept || ((fsm_q == StDraw) && !cand_ok && !last_try);
        step_adv  = step && (fsm_q != StDraw);
    end

    // Request FSM, registered response fields and the LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= StIdle;
            state_q        <= SeedInit;
            bound_q        <= '0;
            mask_q         <= '0;
            retry_cnt_q    <= '0;
            rsp_data_q     <= '0;
            rsp_fallback_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (accept) begin
                        bound_q     <= req_bound;
                        mask_q      <= mask_for(req_bound);
                        retry_cnt_q <= '0;
                        fsm_q       <= StDraw;
                    end
                end
                StDraw: begin
                    // A seed load replaces the state; this cycle's check is skipped.
                    if (!seed_valid) begin
                        if (cand_ok) begin
                            rsp_data_q     <= cand;
                            rsp_fallback_q <= 1'b0;
                            fsm_q          <= StResp;
                        end else if (last_try) begin
                            rsp_data_q     <= '0;
                            rsp_fallback_q <= 1'b1;
                            fsm_q          <= StResp;
                        end else begin
                            retry_cnt_q <= retry_cnt_q + CntW'(1);
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        fsm_q <= StIdle;
                    end
                end
                default: fsm_q <= StIdle;
            endcase

            if (seed_valid) begin
                state_q <= seed_val;
            end else if (draw_adv || step_adv) begin
                state_q <= state_adv;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: randomized and directed checks of lfsr_rng against a behavioural model.
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        rst, step, seed_valid, req_valid, rsp_ready;
    logic [63:0] seed_data;
    logic [7:0]  req_bound;

    logic [63:0] lfsr, lfsr_fb, lfsr_dist;
    logic [7:0]  lfsr_lk;
    logic        req_ready, rsp_valid, rsp_fallback;
    logic [7:0]  rsp_data;
    logic        req_ready_fb, rsp_valid_fb, rsp_fallback_fb;
    logic [7:0]  rsp_data_fb;
    logic        req_ready_dist, rsp_valid_dist, rsp_fallback_dist;
    logic [7:0]  rsp_data_dist;
    logic        req_ready_lk, rsp_valid_lk, rsp_fallback_lk;
    logic [7:0]  rsp_data_lk;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Default build: model-checked every cycle.
    lfsr_rng u_dut (
        .clk(clk), .rst(rst), .step(step), .lfsr(lfsr), .seed_valid(seed_valid),
        .seed_data(seed_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_bound(req_bound), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fallback(rsp_fallback)
    );

    // Single-try build for the fallback path.
    lfsr_rng #(.MAX_RETRY(1)) u_fb (
        .clk(clk), .rst(rst), .step(step), .lfsr(lfsr_fb), .seed_valid(seed_valid),
        .seed_data(seed_data), .req_valid(req_valid), .req_ready(req_ready_fb),
        .req_bound(req_bound), .rsp_valid(rsp_valid_fb), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_fb), .rsp_fallback(rsp_fallback_fb)
    );

    // Eight shifts per advance so successive candidates use fresh bits.
    lfsr_rng #(.STEPS(8)) u_dist (
        .clk(clk), .rst(rst), .step(step), .lfsr(lfsr_dist), .seed_valid(seed_valid),
        .seed_data(seed_data), .req_valid(req_valid), .req_ready(req_ready_dist),
        .req_bound(req_bound), .rsp_valid(rsp_valid_dist), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_dist), .rsp_fallback(rsp_fallback_dist)
    );

    // No taps and zero seed: exercises the lockup escape.
    lfsr_rng #(.WIDTH(8), .TAP_MASK(8'h00), .SEED(8'h00)) u_lk (
        .clk(clk), .rst(rst), .step(step), .lfsr(lfsr_lk), .seed_valid(seed_valid),
        .seed_data(seed_data[7:0]), .req_valid(req_valid), .req_ready(req_ready_lk),
        .req_bound(req_bound), .rsp_valid(rsp_valid_lk), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_lk), .rsp_fallback(rsp_fallback_lk)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of u_dut (default parameters) ----------------
    localparam logic [63:0] M_SEED = 64'h1234_5678_8765_4321;
    localparam logic [63:0] M_TAPS = 64'h1B;

    logic [63:0] m_state;
    int          m_phase;   // 0 waiting for request, 1 drawing, 2 holding response
    int          m_bound, m_span, m_tries, m_data, m_fb;

    function automatic logic [63:0] m_adv(input logic [63:0] s);
        int fb;
        if (s == 64'd0) return 64'd1;
        fb = $countones(s & M_TAPS) % 2;
        return (s >> 1) + (fb == 1 ? 64'h8000_0000_0000_0000 : 64'd0);
    endfunction

    function automatic int m_span_of(input int b);
        int p;
        if (b == 0) return 256;
        p = 1;
        while (p < b) p = p * 2;
        return p;
    endfunction

    task automatic m_cycle(input logic r, input logic sv, input logic [63:0] sd,
                           input logic st, input logic rv, input int b, input logic rr);
        int cand;
        if (r) begin
            m_state = M_SEED; m_phase = 0; m_data = 0; m_fb = 0;
            return;
        end
        case (m_phase)
            0: if (!sv && rv) begin
                m_bound = b; m_span = m_span_of(b); m_tries = 0;
                m_state = m_adv(m_state); m_phase = 1;
            end else if (!sv && st) m_state = m_adv(m_state);
            1: if (!sv) begin
                cand = int'(m_state[7:0]) % m_span;
                if (m_bound == 0 || cand < m_bound) begin
                    m_data = cand; m_fb = 0; m_phase = 2;
                end else if (m_tries + 1 == 4) begin
                    m_data = 0; m_fb = 1; m_phase = 2;
                end else begin
                    m_state = m_adv(m_state); m_tries++;
                end
            end
            default: begin
                if (!sv && st) m_state = m_adv(m_state);
                if (rr) m_phase = 0;
            end
        endcase
        if (sv) m_state = (sd == 64'd0) ? 64'd1 : sd;
    endtask

    // Compare process: req_ready mid-cycle, registered outputs just after the edge.
    initial begin
        m_state = 64'd0; m_phase = 0; m_data = 0; m_fb = 0;
        m_bound = 0; m_span = 256; m_tries = 0;
        forever begin
            @(negedge clk);
            #2;
            chk("req_ready", {63'd0, req_ready}, {63'd0, (m_phase == 0 && !rst && !seed_valid)});
            m_cycle(rst, seed_valid, seed_data, step, req_valid, int'(req_bound), rsp_ready);
            @(posedge clk);
            #1;
            chk("lfsr", lfsr, m_state);
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, (m_phase == 2)});
            chk("rsp_data", {56'd0, rsp_data}, 64'(m_data));
            chk("rsp_fallback", {63'd0, rsp_fallback}, 64'(m_fb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    task automatic idle_inputs;
        step = 0; seed_valid = 0; seed_data = 64'd0; req_valid = 0; req_bound = 8'd0;
        rsp_ready = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin : stim
        int cnt [3];
        int draws, cyc, bad_val;
        rst = 1; idle_inputs();
        tick(); tick(); tick();
        // Reset state.
        chk("rst_lfsr", lfsr, 64'h1234_5678_8765_4321);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_zero_seed", {56'd0, lfsr_lk}, 64'd1);
        rst = 0;

        // One step from the default seed.
        step = 1; tick(); step = 0;
        chk("step1", lfsr, 64'h891A_2B3C_43B2_A190);

        // Full-range draw right after reset.
        do_reset();
        req_valid = 1; req_bound = 8'd0; #1;
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
        tick(); req_valid = 0;
        chk("draw_adv", lfsr, 64'h891A_2B3C_43B2_A190);
        chk("t1_no_rsp", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t2_rsp_data", {56'd0, rsp_data}, 64'h90);
        chk("t2_fallback", {63'd0, rsp_fallback}, 64'd0);
        rsp_ready = 1; tick(); rsp_ready = 0;
        chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);

        // bound 1 always yields 0.
        req_valid = 1; req_bound = 8'd1; tick(); req_valid = 0; tick();
        chk("b1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("b1_data", {56'd0, rsp_data}, 64'd0);
        rsp_ready = 1; tick(); rsp_ready = 0;

        // Zero seed becomes 1; lockup escape in the tapless build.
        seed_valid = 1; seed_data = 64'd0; tick(); seed_valid = 0;
        chk("seed0", lfsr, 64'd1);
        chk("seed0_lk", {56'd0, lfsr_lk}, 64'd1);
        step = 1; tick();
        chk("seed0_step", lfsr, 64'h8000_0000_0000_0000);
        chk("lk_zero", {56'd0, lfsr_lk}, 64'd0);
        tick(); step = 0;
        chk("lk_escape", {56'd0, lfsr_lk}, 64'd1);

        // Fallback with a single try: seed 7 advances to 3, rejected for bound 3.
        seed_valid = 1; seed_data = 64'd7; tick(); seed_valid = 0;
        req_valid = 1; req_bound = 8'd3; tick(); req_valid = 0;
        chk("fb_state", lfsr_fb, 64'd3);
        tick();
        chk("fb_valid", {63'd0, rsp_valid_fb}, 64'd1);
        chk("fb_data", {56'd0, rsp_data_fb}, 64'd0);
        chk("fb_flag", {63'd0, rsp_fallback_fb}, 64'd1);
        tick();
        chk("retry_data", {56'd0, rsp_data}, 64'd1);
        chk("retry_flag", {63'd0, rsp_fallback}, 64'd0);
        rsp_ready = 1;
        for (int i = 0; i < 12; i++) tick();
        rsp_ready = 0;

        // Response hold under step and seed traffic, then reset mid-draw.
        do_reset();
        req_valid = 1; req_bound = 8'd0; tick(); req_valid = 0; tick();
        req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step = (i == 0 || i == 2);
            seed_valid = (i == 1);
            seed_data = 64'hDEAD_BEEF_0000_0001;
            tick();
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_data", {56'd0, rsp_data}, 64'h90);
            if (i == 1) chk("hold_seed", lfsr, 64'hDEAD_BEEF_0000_0001);
            if (i == 2) chk("hold_step", lfsr, 64'hEF56_DF77_8000_0000);
        end
        idle_inputs(); rsp_ready = 1; tick(); rsp_ready = 0; #1;
        chk("back_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1; tick(); req_valid = 0; rst = 1; tick(); rst = 0;
        chk("abort_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_lfsr", lfsr, 64'h1234_5678_8765_4321);
        tick(); tick();
        chk("abort_quiet", {63'd0, rsp_valid}, 64'd0);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 255) == 0);
            seed_valid = ($urandom_range(0, 31) == 0);
            seed_data  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            step       = $urandom_range(0, 1) == 1;
            req_valid  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: req_bound = 8'd0;
                1: req_bound = 8'($urandom_range(1, 3));
                2: req_bound = 8'($urandom_range(4, 40));
                default: req_bound = 8'($urandom);
            endcase
            rsp_ready = $urandom_range(0, 1) == 1;
            tick();
        end

        // Distribution of bound 3 over 10000 draws.
        do_reset();
        req_valid = 1; req_bound = 8'd3; rsp_ready = 1;
        cnt = '{0, 0, 0}; draws = 0; cyc = 0; bad_val = 0;
        while (draws < 10000 && cyc < 60000) begin
            tick(); cyc++;
            if (rsp_valid_dist) begin
                draws++;
                if (rsp_data_dist < 8'd3) cnt[rsp_data_dist] = cnt[rsp_data_dist] + 1;
                else bad_val++;
            end
        end
        chk("dist_draws", 64'(draws), 64'd10000);
        chk("dist_range", 64'(bad_val), 64'd0);
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("dist_%0d_in_31_35pct", v),
                64'(cnt[v] >= 3100 && cnt[v] <= 3500), 64'd1);
        end
        idle_inputs(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised successor of the core's 64-bit Fibonacci LFSR. Adds:
- configurable width, taps and steps per advance;
- runtime seed load;
- a request/response port that returns a uniformly distributed value in [0, bound) using mask-and-reject sampling.
Used for cache/TLB way replacement and the branch-predictor tie-breaker. It can also run free as a raw LFSR.

Parameters:
WIDTH, 64, LFSR state width (>= OUT_W, >= 2)
TAP_MASK, 64'h1B, feedback select; bit i set => state[i] XORed into feedback
SEED, 64'h1234_5678_8765_4321, reset value of state; 0 is replaced by 1
STEPS, 1, serial shifts applied per advance (1..8), all in one cycle
OUT_W, 8, width of bound and rsp_data
MAX_RETRY, 4, rejected draws allowed before fallback (>= 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
step  in  1  free-running advance request
lfsr  out  WIDTH  current state
seed_valid  in  1  load seed_data into state this cycle
seed_data  in  WIDTH  seed value
req_valid  in  1  draw request
req_ready  out  1  high only in IDLE and not in reset
req_bound  in  OUT_W  exclusive upper bound; 0 = full 2^OUT_W range
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  OUT_W  drawn value
rsp_fallback  out  1  response produced by retry exhaustion

Behaviour:
- One shift: fb = XOR of state[i] for every i with TAP_MASK[i]=1; state <= {fb, state[WIDTH-1:1]}.
- An advance applies STEPS shifts combinationally. If state==0 at an advance, the next state is 1 and no shift occurs (lockup escape).
- Reset:
  - state <= SEED (1 if SEED==0), FSM <= IDLE.
  - rsp_valid, rsp_data and rsp_fallback all 0.
  - req_ready 0 while rst is high.
- State update priority per cycle: rst > seed_valid > draw advance (FSM) > step.
  - Seed load: state <= seed_data, or 1 if seed_data==0. No advance occurs that cycle.
  - step is honoured only in IDLE and RESP. It is ignored in DRAW.
- FSM states: IDLE, DRAW, RESP.
  - IDLE: req_ready=1.
    - On req_valid & ~seed_valid: latch bound, compute mask = 2^k-1 for the smallest k with 2^k >= bound (all ones if bound==0).
    - Same cycle: advance state, clear retry_cnt, go to DRAW.
    - req_valid with seed_valid the same cycle is not accepted (req_ready forced low).
  - DRAW: cand = state[OUT_W-1:0] & mask.
    - If bound==0 or cand < bound: rsp_data <= cand, rsp_fallback <= 0, go to RESP.
    - Else, if retry_cnt == MAX_RETRY-1: rsp_data <= 0, rsp_fallback <= 1, go to RESP.
    - Else: advance state, retry_cnt++, stay in DRAW.
    - A seed load during DRAW replaces state. Evaluation continues from the new state next cycle, and that cycle's check is suppressed (no response, no retry increment).
  - RESP: rsp_valid=1. rsp_data and rsp_fallback are held stable until rsp_ready. On rsp_ready go to IDLE, and rsp_valid drops the next cycle.
- Latency:
  - request accepted at cycle t => earliest rsp_valid at t+2;
  - each rejection adds 1 cycle;
  - worst case is t+1+MAX_RETRY.
- One request in flight. No new request is accepted until the response handshake completes and IDLE is re-entered.
- bound==1 gives mask 0 and always returns 0 with no rejection.
- Reset mid-transaction aborts it. No response is emitted.
- lfsr always shows the current registered state.

Test Plan:
1. Defaults, reset released, step=1 for one cycle -> lfsr 0x1234_5678_8765_4321 becomes 0x891A_2B3C_43B2_A190.
2. seed_valid with seed_data=0 -> lfsr=1; one step -> lfsr=0x8000_0000_0000_0000; with step held on state 0 (forced via seed in a WIDTH=8, TAP_MASK=0 build) -> returns to 1, never sticks at 0.
3. After reset, req_valid with bound=0 at cycle t -> state advances to 0x...A190; rsp_valid at t+2 with rsp_data=0x90, rsp_fallback=0.
4. bound=1 -> rsp_data=0 at t+2 regardless of state; bound=3 over 10k draws -> values only in {0,1,2}, each 33% ±2%.
5. MAX_RETRY=1, seed 0x7, bound=3 -> advance gives state 0x3, cand=3 rejected -> rsp_data=0, rsp_fallback=1 at t+2.
6. Hold rsp_ready=0 for 5 cycles while pulsing step and seed_valid -> rsp_data stable, req_ready=0 throughout, step advances lfsr in RESP, seed loads; rsp_ready=1 -> IDLE next cycle, req_ready=1; rst asserted during DRAW -> no response, outputs at reset values.
